// File: rtl/cnt_multi.sv
// cnt_multi: multi-mode counter (up/down/bounce) with prescaler, one-shot/free-run, load and terminal flags
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start/stop    arm (restart) / halt pulses; load/load_val parallel load
//   top, mode     terminal value; 0 up, 1 down, 2 bounce, 3 up
//   freerun       restart after terminal when set, else drop to idle
//   prescale      count advances every prescale+1 clocks
//   clr_it        clears sticky it
//   cnt, dir      count and direction (1 = down)
//   running       high in RUN; tc one-cycle terminal pulse; it sticky terminal flag
module cnt_multi #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] top,
   input  logic [1:0]       mode,
   input  logic             freerun,
   input  logic [PRE_W-1:0] prescale,
   input  logic             clr_it,
   output logic [WIDTH-1:0] cnt,
   output logic             dir,
   output logic             running,
   output logic             tc,
   output logic             it
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state;
   logic [PRE_W-1:0] pre;
   logic             tick, term, nxt_dir;
   logic [WIDTH-1:0] nxt_cnt;
   assign running = (state == RUN);
   assign tick    = (state == RUN) && (pre == prescale);
   // next count/direction if this cycle were a tick; mode 3 falls through to up
   always_comb begin
      nxt_cnt = cnt;
      nxt_dir = dir;
      term    = 1'b0;
      if (mode == 2'd1) begin
         nxt_dir = 1'b1;
         term    = (cnt == '0);
         nxt_cnt = term ? (freerun ? top : '0) : cnt - 1'b1;
      end else if (mode == 2'd2) begin
         if (!dir) begin
            if (cnt < top) nxt_cnt = cnt + 1'b1;
            else if (top == '0) term = 1'b1;
            else begin
               nxt_dir = 1'b1;
               nxt_cnt = cnt - 1'b1;
            end
         end else if (cnt != '0) nxt_cnt = cnt - 1'b1;
         else term = 1'b1;
         if (term) begin
            nxt_cnt = (freerun && top != '0) ? WIDTH'(1) : '0;
            nxt_dir = freerun ? 1'b0 : dir;
         end
      end else begin
         nxt_dir = 1'b0;
         term    = (cnt >= top);
         nxt_cnt = term ? (freerun ? '0 : cnt) : cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pre   <= '0;
         cnt   <= '0;
         dir   <= 1'b0;
         tc    <= 1'b0;
         it    <= 1'b0;
      end else begin
         tc <= 1'b0;
         it <= it & ~clr_it;
         if (load) begin
            cnt <= load_val;
            pre <= '0;
         end else if (stop) begin
            state <= IDLE;
            pre   <= '0;
         end else if (start) begin
            state <= RUN;
            pre   <= '0;
            cnt   <= (mode == 2'd1) ? top : '0;
            dir   <= (mode == 2'd1);
         end else if (state == RUN) begin
            // a prescale below the current pre value lets pre run through its natural wrap
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
               cnt <= nxt_cnt;
               dir <= nxt_dir;
               if (term) begin
                  tc <= 1'b1;
                  it <= 1'b1;
                  if (!freerun) state <= IDLE;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_cnt_multi.sv
// tb_cnt_multi: directed self-checking bench for cnt_multi
module tb_cnt_multi;
   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0, freerun = 1'b0, clr_it = 1'b0;
   logic [7:0]  load_val = '0, top = '0, cnt;
   logic [1:0]  mode = '0;
   logic [15:0] prescale = '0;
   logic        dir, running, tc, it;
   int          n_chk = 0, n_fail = 0;
   cnt_multi #(.WIDTH(8), .PRE_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load), .load_val(load_val),
      .top(top), .mode(mode), .freerun(freerun), .prescale(prescale), .clr_it(clr_it),
      .cnt(cnt), .dir(dir), .running(running), .tc(tc), .it(it)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   int bc[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
   int bd[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
   int bt[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   initial begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_cnt", cnt, 0);
      check("rst_run", running, 0);
      check("rst_tc", tc, 0);
      check("rst_it", it, 0);
      check("rst_dir", dir, 0);
      // free-run up, top=3
      mode = 2'd0; top = 8'd3; prescale = '0; freerun = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("up_start_cnt", cnt, 0);
      check("up_start_run", running, 1);
      for (int i = 1; i <= 8; i++) begin
         step();
         check("up_cnt", cnt, i % 4);
         check("up_tc", tc, (i % 4 == 0) ? 1 : 0);
      end
      check("up_it_set", it, 1);
      clr_it = 1'b1;
      step();
      clr_it = 1'b0;
      check("up_it_clr", it, 0);
      check("up_cnt_after_clr", cnt, 1);
      step();
      step();
      clr_it = 1'b1;
      step();
      clr_it = 1'b0;
      check("up_set_wins_tc", tc, 1);
      check("up_set_wins_it", it, 1);
      // reset mid-run
      top = 8'd5;
      step();
      step();
      step();
      check("mid_cnt3", cnt, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_cnt", cnt, 0);
      check("mid_rst_run", running, 0);
      check("mid_rst_it", it, 0);
      step();
      check("mid_idle_cnt", cnt, 0);
      // prescaled one-shot down
      mode = 2'd1; top = 8'd2; prescale = 16'd2; freerun = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("dn_start_cnt", cnt, 2);
      check("dn_start_dir", dir, 1);
      for (int k = 1; k <= 9; k++) begin
         step();
         check("dn_cnt", cnt, k < 3 ? 2 : (k < 6 ? 1 : 0));
         check("dn_tc", tc, k == 9 ? 1 : 0);
         check("dn_run", running, k < 9 ? 1 : 0);
      end
      step();
      check("dn_hold_cnt", cnt, 0);
      check("dn_hold_tc", tc, 0);
      check("dn_it", it, 1);
      // bounce free-run, top=3
      mode = 2'd2; top = 8'd3; prescale = '0; freerun = 1'b1;
      start = 1'b1; clr_it = 1'b1;
      step();
      start = 1'b0; clr_it = 1'b0;
      check("bn_start_cnt", cnt, 0);
      check("bn_start_dir", dir, 0);
      check("bn_start_it", it, 0);
      for (int k = 0; k < 8; k++) begin
         step();
         check("bn_cnt", cnt, bc[k]);
         check("bn_dir", dir, bd[k]);
         check("bn_tc", tc, bt[k]);
      end
      // priority: load beats stop and start
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_run", running, 0);
      check("stop_cnt", cnt, 2);
      load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 8'd9;
      step();
      load = 1'b0; stop = 1'b0; start = 1'b0;
      check("prio_cnt", cnt, 9);
      check("prio_run", running, 0);
      mode = 2'd0; top = 8'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      check("ld_start_cnt", cnt, 0);
      load = 1'b1;
      step();
      load = 1'b0;
      check("ld_cnt", cnt, 9);
      check("ld_no_tick_tc", tc, 0);
      step();
      check("ld_term_cnt", cnt, 0);
      check("ld_term_tc", tc, 1);
      // top=0 up free-run
      top = 8'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t0_cnt", cnt, 0);
         check("t0_tc", tc, 1);
      end
      // full-range down free-run, then mode change mid-run
      mode = 2'd1; top = 8'd255;
      start = 1'b1;
      step();
      start = 1'b0;
      check("d255_start", cnt, 255);
      for (int k = 0; k < 255; k++) step();
      check("d255_zero", cnt, 0);
      check("d255_zero_tc", tc, 0);
      step();
      check("d255_reload", cnt, 255);
      check("d255_tc", tc, 1);
      step();
      check("d255_254", cnt, 254);
      mode = 2'd0;
      step();
      check("mchg_cnt", cnt, 255);
      check("mchg_dir", dir, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cnt_multi.md
Name: cnt_multi

Overview:
- Parametrised successor to the board-level free-running LED counter and the basic up-counter with terminal flag.
- Adds up, down and bounce modes, a programmable prescaler, one-shot or free-run operation, and parallel load.
- A sticky terminal flag plus a one-cycle terminal pulse drive LEDs or interrupt logic directly.
- Replaces the external clock divider plus counter pair in board tops.

Parameters:
- WIDTH, 8, counter width in bits.
- PRE_W, 16, prescaler width in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; arms counter and begins counting.
- stop  input  1  pulse; halts counting, holds cnt.
- load  input  1  pulse; cnt <= load_val.
- load_val  input  WIDTH  value for load.
- top  input  WIDTH  terminal value.
- mode  input  2  0 = up, 1 = down, 2 = bounce, 3 = reserved (treated as up).
- freerun  input  1  1 = restart after terminal; 0 = one-shot.
- prescale  input  PRE_W  count advances every prescale+1 clocks.
- clr_it  input  1  clears sticky flag.
- cnt  output  WIDTH  current count.
- dir  output  1  0 = counting up, 1 = counting down.
- running  output  1  high while in RUN.
- tc  output  1  one-cycle terminal pulse.
- it  output  1  sticky terminal flag.

Behaviour:
- Reset (rst=1 at clk edge):
  - cnt=0, dir=0, running=0, tc=0, it=0.
  - Prescaler counter=0, state=IDLE.
  - Reset overrides all other inputs.
- States:
  - IDLE: no counting.
  - RUN: counting on each tick.
- Command priority in one cycle: rst > load > stop > start > tick.
- start:
  - From IDLE or RUN: state=RUN, prescaler cleared.
  - cnt = 0 for up/bounce, top for down. dir = 1 for down, else 0.
  - No count advance in the start cycle.
- stop: state=IDLE; cnt, dir, it unchanged; prescaler cleared.
- load: cnt=load_val; state, dir unchanged; prescaler cleared; no tick that cycle.
- Prescaler:
  - Runs only in RUN.
  - tick=1 when prescaler==prescale, then prescaler wraps to 0; otherwise increments.
  - prescale=0 gives a tick every clock.
  - A prescale change takes effect on the next compare. If prescaler > prescale, it counts through 2^PRE_W wrap (documented, not an error).
- Up (on tick):
  - cnt<top: cnt+1.
  - cnt>=top: terminal event.
- Down (on tick):
  - cnt>0: cnt-1.
  - cnt==0: terminal event.
- Bounce (on tick):
  - dir=0: cnt+1 until cnt>=top, then dir=1 and cnt-1. Turnaround is not terminal.
  - dir=1: cnt-1 until cnt==0, then terminal event.
  - top=0 in bounce: every tick is terminal, cnt stays 0.
- Terminal event:
  - tc=1 for exactly that cycle; it=1.
  - freerun=1: up wraps cnt to 0; down reloads top; bounce sets dir=0, cnt=1 (or 0 if top=0). Stays in RUN.
  - freerun=0: up holds cnt at top (or current value if >top); down/bounce hold 0. state=IDLE.
- Timing: cnt, tc, it, running are registered; tc and the new it appear in the same cycle as the terminal cnt update.
- it clears on clr_it; if set and clear coincide, set wins.
- top change mid-run: the comparison uses the current top each tick. cnt>top in up mode terminates on the next tick.
- mode change mid-run: takes effect on the next tick; dir is forced consistent (up → 0, down → 1).
- Arithmetic is unsigned, modulo 2^WIDTH; no other wrap path exists.

Test Plan:
- Reset mid-run: WIDTH=4, up, top=5, running at cnt=3; assert rst one cycle -> cnt=0, running=0, it=0 next cycle; no tick while rst high.
- Free-run up: prescale=0, top=3, start -> cnt 0,1,2,3,0,1…; tc high on each 3→0 cycle; it set; clr_it clears it; clr_it coincident with tc keeps it=1.
- Prescale plus one-shot down: prescale=2, top=2, freerun=0, start -> cnt changes every 3 clocks 2,1,0; tc once; running=0 after; cnt holds 0.
- Bounce free-run: top=3 -> cnt 0,1,2,3,2,1,0,1…; dir toggles at 3 and at 0; tc only when 0 is reached while counting down.
- Priority and load: load=1, stop=1, start=1 together with load_val=9 -> cnt=9, state IDLE. Then in up mode with top=5, start, load 9 -> next tick is terminal, cnt=0.
- Edge values: top=0 up free-run -> tc every tick, cnt=0. WIDTH=8 down with top=255 -> 255..0 then reload 255.
